// File: rtl/vga_scanout.sv
// vga_scanout: reads a 160x120 3-bit framebuffer in raster order and drives a
// 640x480@60 VGA DAC with every stored pixel replicated 4x4. It also emits
// vblank / vblank_start so the draw side can pace its updates to the frame.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] rd_addr,
    output logic        rd_en,
    input  logic [2:0]  rd_data,
    output logic        vblank,
    output logic        vblank_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B
);

    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       phase;
    logic       advance;
    logic [9:0] h_p0;
    logic [9:0] v_p0;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       act_p0;
    logic       hs_p1;
    logic       vs_p1;
    logic       vld_p1;
    logic [9:0] r_p1;
    logic [9:0] g_p1;
    logic [9:0] b_p1;
    logic       vblank_p1;
    logic       vbs_p1;

    // Framebuffer address of screen pixel (hc,vc): y*160 + x without a multiplier.
    function automatic logic [14:0] fb_addr(input logic [9:0] hc, input logic [9:0] vc);
        logic [14:0] x;
        logic [14:0] y;
        x = 15'(hc >> 2);
        y = 15'(vc >> 2);
        return (y << 7) + (y << 5) + x;
    endfunction

    // Expand one stored colour bit to a full-scale DAC channel, black outside the picture.
    function automatic logic [9:0] expand(input logic bit_in, input logic en);
        return (en && bit_in) ? 10'h3FF : 10'h000;
    endfunction

    // Pixel-clock phase: toggles every clk; an edge with phase==1 advances the raster.
    always_ff @(posedge clk) begin
        if (reset) phase <= 1'b0;
        else       phase <= ~phase;
    end

    assign advance = phase;

    // Raster successor position, including the line and frame wraps.
    always_comb begin
        h_nxt = h_p0 + 10'd1;
        v_nxt = v_p0;
        if (h_p0 == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_p0 == V_LAST) ? 10'd0 : v_p0 + 10'd1;
        end
    end

    // Stage 0: raster counters, moving one pixel per advance edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (advance) begin
            h_p0 <= h_nxt;
            v_p0 <= v_nxt;
        end
    end

    // Read port is driven straight from the stage 0 counters; the RAM supplies the
    // data during the following phase==1 cycle.
    assign act_p0  = (h_p0 < H_VIS) && (v_p0 < V_VIS);
    assign rd_en   = act_p0 && !reset;
    assign rd_addr = act_p0 ? fb_addr(h_p0, v_p0) : 15'd0;

    // Stage 1: DAC-facing registers, loaded from the pre-advance position so sync,
    // blank and colour for a pixel all change together on the falling VGA_CLK.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_p1     <= 1'b1;
            vs_p1     <= 1'b1;
            vld_p1    <= 1'b0;
            r_p1      <= '0;
            g_p1      <= '0;
            b_p1      <= '0;
            vblank_p1 <= 1'b0;
            vbs_p1    <= 1'b0;
        end else begin
            vbs_p1 <= 1'b0;
            if (advance) begin
                hs_p1     <= !((h_p0 >= HS_FIRST) && (h_p0 <= HS_LAST));
                vs_p1     <= !((v_p0 >= VS_FIRST) && (v_p0 <= VS_LAST));
                vld_p1    <= act_p0;
                r_p1      <= expand(rd_data[2], act_p0);
                g_p1      <= expand(rd_data[1], act_p0);
                b_p1      <= expand(rd_data[0], act_p0);
                vblank_p1 <= (v_nxt >= V_VIS);
                vbs_p1    <= (h_p0 == H_LAST) && (v_p0 == V_VIS_LAST);
            end
        end
    end

    assign VGA_CLK      = phase;
    assign VGA_HS       = hs_p1;
    assign VGA_VS       = vs_p1;
    assign VGA_BLANK_N  = vld_p1;
    assign VGA_SYNC_N   = 1'b1;
    assign VGA_R        = r_p1;
    assign VGA_G        = g_p1;
    assign VGA_B        = b_p1;
    assign vblank       = vblank_p1;
    assign vblank_start = vbs_p1;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout. Horizontal timing is the
// full 800-pixel line; the frame is shortened to 15 lines (8 visible, FP 2,
// sync 2, BP 3) so two frames fit in a short run. One line = 1600 clk,
// one frame = 24000 clk. cyc counts clk edges since reset release (edge 1 is the
// first edge with reset low); after edge 2p the counters sit on pixel p and the
// DAC registers show pixel p-1.
module tb_vga_scanout;

    localparam int V_ACT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic [2:0]  rd_data;
    logic        vblank, vblank_start;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0]  VGA_R, VGA_G, VGA_B;

    always #10 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(V_ACT), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .vblank(vblank), .vblank_start(vblank_start),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    // RAM model: one-cycle read latency, returns addr[2:0]; when not enabled it
    // returns 3'b111 so any leak of blanking data shows up as colour.
    always @(posedge clk) rd_data <= rd_en ? rd_addr[2:0] : 3'b111;

    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: expected value of one DUT signal at one cycle.
    int          q_cyc[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];

    task automatic sb_push(input int c, input int s, input logic [31:0] e);
        q_cyc.push_back(c);
        q_sel.push_back(s);
        q_exp.push_back(e);
    endtask

    function automatic logic [31:0] probe(input int s);
        case (s)
            0:  return 32'(rd_addr);
            1:  return 32'(rd_en);
            2:  return 32'(VGA_R);
            3:  return 32'(VGA_G);
            4:  return 32'(VGA_B);
            5:  return 32'(VGA_BLANK_N);
            6:  return 32'(VGA_HS);
            7:  return 32'(VGA_VS);
            8:  return 32'(vblank);
            9:  return 32'(vblank_start);
            default: return 32'(VGA_CLK);
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            0:  return "rd_addr";
            1:  return "rd_en";
            2:  return "VGA_R";
            3:  return "VGA_G";
            4:  return "VGA_B";
            5:  return "VGA_BLANK_N";
            6:  return "VGA_HS";
            7:  return "VGA_VS";
            8:  return "vblank";
            9:  return "vblank_start";
            default: return "VGA_CLK";
        endcase
    endfunction

    // Monitor: compare every scoreboard entry due at the current cycle.
    always @(negedge clk) begin
        if (!reset) begin
            while (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
                check(sig_name(q_sel[0]), probe(q_sel[0]), q_exp[0]);
                void'(q_cyc.pop_front());
                void'(q_sel.pop_front());
                void'(q_exp.pop_front());
            end
        end
    end

    // Edge recorder for the timing measurements.
    bit   meas_on = 1'b0;
    logic hs_q, vs_q, bn_q, vbs_q, vb_q, vc_q;
    int   hs_fall[$], hs_rise[$], bn_rise[$], bn_fall[$], vs_fall[$], vs_rise[$];
    int   vbs_rise[$], vbs_fall[$], vb_rise[$], vb_fall[$], vc_rise[$];

    always @(negedge clk) begin
        if (meas_on) begin
            if (hs_q === 1'b1 && VGA_HS === 1'b0)      hs_fall.push_back(cyc);
            if (hs_q === 1'b0 && VGA_HS === 1'b1)      hs_rise.push_back(cyc);
            if (bn_q === 1'b0 && VGA_BLANK_N === 1'b1) bn_rise.push_back(cyc);
            if (bn_q === 1'b1 && VGA_BLANK_N === 1'b0) bn_fall.push_back(cyc);
            if (vs_q === 1'b1 && VGA_VS === 1'b0)      vs_fall.push_back(cyc);
            if (vs_q === 1'b0 && VGA_VS === 1'b1)      vs_rise.push_back(cyc);
            if (vbs_q === 1'b0 && vblank_start === 1'b1) vbs_rise.push_back(cyc);
            if (vbs_q === 1'b1 && vblank_start === 1'b0) vbs_fall.push_back(cyc);
            if (vb_q === 1'b0 && vblank === 1'b1)      vb_rise.push_back(cyc);
            if (vb_q === 1'b1 && vblank === 1'b0)      vb_fall.push_back(cyc);
            if (vc_q === 1'b0 && VGA_CLK === 1'b1)     vc_rise.push_back(cyc);
        end
        hs_q  <= VGA_HS;
        vs_q  <= VGA_VS;
        bn_q  <= VGA_BLANK_N;
        vbs_q <= vblank_start;
        vb_q  <= vblank;
        vc_q  <= VGA_CLK;
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_hs"},      32'(VGA_HS), 1);
        check({tag, "_vs"},      32'(VGA_VS), 1);
        check({tag, "_blank_n"}, 32'(VGA_BLANK_N), 0);
        check({tag, "_r"},       32'(VGA_R), 0);
        check({tag, "_g"},       32'(VGA_G), 0);
        check({tag, "_b"},       32'(VGA_B), 0);
        check({tag, "_rd_en"},   32'(rd_en), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_vga_clk"}, 32'(VGA_CLK), 0);
        check({tag, "_vblank"},  32'(vblank), 0);
        check({tag, "_vbstart"}, 32'(vblank_start), 0);
        check({tag, "_sync_n"},  32'(VGA_SYNC_N), 1);
    endtask

    initial begin
        int t_fall;
        logic hs_prev;

        // Reset held for 5 clk.
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");

        // Directed expectations, in cycle order. Pixel p is on the read port after
        // edge 2p and on the DAC outputs after edge 2p+2.
        sb_push(6,     0, 0);      sb_push(6,     1, 1);       // (3,0)   addr 0
        sb_push(8,     0, 1);      sb_push(8,     1, 1);       // (4,0)   addr 1
        sb_push(14,    0, 1);                                  // (7,0)   addr 1
        sb_push(16,    2, 0);      sb_push(16,    3, 0);       // pixel (7,0) data 001
        sb_push(16,    4, 10'h3FF); sb_push(16,   5, 1);
        sb_push(42,    2, 10'h3FF); sb_push(42,   3, 0);       // pixel (20,0) data 101
        sb_push(42,    4, 10'h3FF);
        sb_push(100,   10, 0);     sb_push(101,   10, 1);      // VGA_CLK phase
        sb_push(1278,  0, 159);    sb_push(1278,  1, 1);       // (639,0) addr 159
        sb_push(1280,  0, 0);      sb_push(1280,  1, 0);       // (640,0) read off
        sb_push(1280,  5, 1);      sb_push(1280,  2, 10'h3FF); // pixel (639,0) data 111
        sb_push(1282,  5, 0);      sb_push(1282,  2, 0);       // pixel (640,0) blank, RAM 111
        sb_push(1282,  3, 0);      sb_push(1282,  4, 0);
        sb_push(1312,  6, 1);      sb_push(1314,  6, 0);       // h=655 / 656
        sb_push(1504,  6, 0);      sb_push(1506,  6, 1);       // h=751 / 752
        sb_push(6400,  0, 160);    sb_push(6400,  1, 1);       // (0,4)   addr 160
        sb_push(12478, 0, 319);    sb_push(12478, 1, 1);       // (639,7) addr 319
        sb_push(12480, 2, 10'h3FF); sb_push(12480, 3, 10'h3FF); // pixel (639,7) data 111
        sb_push(12480, 4, 10'h3FF); sb_push(12480, 5, 1);
        sb_push(12799, 8, 0);      sb_push(12799, 9, 0);       // still at (799,7)
        sb_push(12800, 0, 0);      sb_push(12800, 1, 0);       // entered (0,8)
        sb_push(12800, 8, 1);      sb_push(12800, 9, 1);
        sb_push(12801, 8, 1);      sb_push(12801, 9, 0);
        sb_push(12802, 5, 0);      sb_push(12802, 2, 0);
        sb_push(16000, 7, 1);      sb_push(16002, 7, 0);       // v=9 / v=10
        sb_push(19200, 7, 0);      sb_push(19202, 7, 1);       // v=11 / v=12
        sb_push(23999, 8, 1);      sb_push(24000, 8, 0);       // frame wrap

        reset   = 1'b0;
        meas_on = 1'b1;
        repeat (41000) @(negedge clk);
        meas_on = 1'b0;

        check("sb_drained", 32'(q_cyc.size()), 0);

        // Line timing.
        check("hs_first_fall", (hs_fall.size() >= 1) ? hs_fall[0] : -1, 1314);
        check("hs_period_1",   (hs_fall.size() >= 2) ? hs_fall[1] - hs_fall[0] : -1, 1600);
        check("hs_period_2",   (hs_fall.size() >= 3) ? hs_fall[2] - hs_fall[1] : -1, 1600);
        check("hs_low_width",  (hs_fall.size() >= 1 && hs_rise.size() >= 1) ? hs_rise[0] - hs_fall[0] : -1, 192);
        check("blank_n_rise",  (bn_rise.size() >= 1) ? bn_rise[0] : -1, 2);
        check("blank_n_high",  (bn_rise.size() >= 1 && bn_fall.size() >= 1) ? bn_fall[0] - bn_rise[0] : -1, 1280);
        check("vga_clk_period", (vc_rise.size() >= 2) ? vc_rise[1] - vc_rise[0] : -1, 2);
        // Frame timing.
        check("vs_low_width",  (vs_fall.size() >= 1 && vs_rise.size() >= 1) ? vs_rise[0] - vs_fall[0] : -1, 3200);
        check("vs_period",     (vs_fall.size() >= 2) ? vs_fall[1] - vs_fall[0] : -1, 24000);
        check("vbstart_width", (vbs_rise.size() >= 1 && vbs_fall.size() >= 1) ? vbs_fall[0] - vbs_rise[0] : -1, 1);
        check("vbstart_period", (vbs_rise.size() >= 2) ? vbs_rise[1] - vbs_rise[0] : -1, 24000);
        check("vbstart_count", 32'(vbs_rise.size()), 2);
        check("vblank_high",   (vb_rise.size() >= 1 && vb_fall.size() >= 1) ? vb_fall[0] - vb_rise[0] : -1, 11200);

        // Mid-frame reset at (300,2) of the third frame (edge 48000 + 2*1900).
        while (cyc != 51800) @(negedge clk);
        check("mid_blank_n", 32'(VGA_BLANK_N), 1);
        check("mid_rd_en",   32'(rd_en), 1);
        check("mid_rd_addr", 32'(rd_addr), 75);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;

        // First HS fall after release: pixel h=656 reaches the outputs on edge 1314.
        t_fall  = -1;
        hs_prev = VGA_HS;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hs_prev === 1'b1 && VGA_HS === 1'b0) begin
                t_fall = cyc;
                break;
            end
            hs_prev = VGA_HS;
        end
        check("hs_after_reset", t_fall, 1314);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
